rggen_demux_write: RTL

RGGEN_DEMUX_WRITE -- requirements
Module: rggen_demux_write

---
 rtl/rggen_demux_write.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rggen_demux_write.sv
// Write demultiplexer: accepts one write request, strobes the addressed lane until it
// acknowledges (or an optional timeout expires), then reports completion and status.
module rggen_demux_write #(
    parameter int WIDTH       = 32,
    parameter int ENTRIES     = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [INDEX_WIDTH-1:0]   i_index,
    input  logic [WIDTH-1:0]         i_data,
    output logic [ENTRIES-1:0]       o_select,
    output logic [WIDTH*ENTRIES-1:0] o_data,
    input  logic [ENTRIES-1:0]       i_ack,
    output logic                     o_done,
    output logic                     o_error
);

    localparam int                     CNT_WIDTH   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0]   CNT_LAST    = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [INDEX_WIDTH:0]   ENTRIES_VAL = (INDEX_WIDTH + 1)'(ENTRIES);
    localparam logic                   TIMEOUT_ON  = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                   state_r, state_s;
    logic [INDEX_WIDTH-1:0]   index_r, index_s;
    logic [WIDTH-1:0]         data_r, data_s;
    logic                     flag_r, flag_s;
    logic [CNT_WIDTH-1:0]     count_r, count_s;
    logic                     handshake_s, ack_hit_s, expire_s;
    logic                     ready_s, done_s, error_s;
    logic [ENTRIES-1:0]       select_s;
    logic [WIDTH*ENTRIES-1:0] out_data_s;

    function automatic logic [ENTRIES-1:0] decode(input logic [INDEX_WIDTH-1:0] idx);
        logic [ENTRIES-1:0] onehot;
        onehot = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            onehot[k] = (idx == INDEX_WIDTH'(k));
        end
        return onehot;
    endfunction

    assign handshake_s = i_valid & o_ready;
    // Only the addressed lane may complete the access; other lanes' acks are masked off.
    assign ack_hit_s   = |(i_ack & decode(index_r));
    assign expire_s    = TIMEOUT_ON & (count_r == CNT_LAST);

    // State and datapath registers, outputs registered from next-state values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            index_r  <= '0;
            data_r   <= '0;
            flag_r   <= 1'b0;
            count_r  <= '0;
            o_ready  <= 1'b0;
            o_select <= '0;
            o_data   <= '0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            data_r   <= data_s;
            flag_r   <= flag_s;
            count_r  <= count_s;
            o_ready  <= ready_s;
            o_select <= select_s;
            o_data   <= out_data_s;
            o_done   <= done_s;
            o_error  <= error_s;
        end
    end

    // Next-state, capture and timeout counter logic.
    always_comb begin
        state_s = state_r;
        index_s = index_r;
        data_s  = data_r;
        flag_s  = flag_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    index_s = i_index;
                    data_s  = i_data;
                    count_s = '0;
                    if ({1'b0, i_index} < ENTRIES_VAL) begin
                        state_s = ACCESS;
                        flag_s  = 1'b0;
                    end else begin
                        state_s = DONE;
                        flag_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (ack_hit_s) begin
                    state_s = DONE;
                    flag_s  = 1'b0;
                end else if (expire_s) begin
                    state_s = DONE;
                    flag_s  = 1'b1;
                end else begin
                    state_s = ACCESS;
                    count_s = count_r + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state.
    always_comb begin
        ready_s    = (state_s == IDLE);
        done_s     = (state_s == DONE);
        error_s    = done_s & flag_s;
        out_data_s = '0;
        if (state_s == ACCESS) begin
            select_s = decode(index_s);
        end else begin
            select_s = '0;
        end
        for (int k = 0; k < ENTRIES; k++) begin
            if (select_s[k]) begin
                out_data_s[WIDTH*k +: WIDTH] = data_s;
            end else begin
                out_data_s[WIDTH*k +: WIDTH] = '0;
            end
        end
    end

endmodule
